mac_seq_ctrl: RTL and testbench

//  Job-level sequencer for the dual-mode 8b/2x4b multiplier.
//  - Accepts a job (mode, length), streams LEN operand pairs through one multiplier instance and accumulates products.
//  - Returns a single partial sum over a valid/ready handshake.
//  - Sits between the PE operand feeders and the psum collection path.

---
 rtl/diff_demo_pkg.sv | 17 +
 rtl/dual_mode_mult.sv | 32 +++
 rtl/psum_lane_acc.sv | 64 ++++++
 rtl/mac_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/diff_demo_pkg.sv
// Shared definitions for the dual-mode multiplier datapath.
//
// Contents:
//   PSUM_WIDTH       width of the accumulated partial sum (24)
//   mac_seq_state_e  job sequencer states (IDLE -> RUN -> DRAIN -> OUT)
package diff_demo_pkg;

    localparam int PSUM_WIDTH = 24;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_RUN,
        MS_DRAIN,
        MS_OUT
    } mac_seq_state_e;

endpackage

// File: rtl/dual_mode_mult.sv
// Dual-mode unsigned multiplier, purely combinational.
//
// Ports:
//   mode  in   0: one 8b x 8b product; 1: two lanes a[7:4]*b and a[3:0]*b
//   a     in   operand a (unsigned, 8 bits)
//   b     in   operand b (unsigned, 8 bits)
//   prod  out  PSUM_WIDTH bits. Mode 0: zero-extended 16-bit product.
//              Mode 1: {upper lane product, lower lane product}, each
//              PSUM_WIDTH/2 bits wide.
module dual_mode_mult
    import diff_demo_pkg::*;
(
    input  logic                  mode,
    input  logic [7:0]            a,
    input  logic [7:0]            b,
    output logic [PSUM_WIDTH-1:0] prod
);

    localparam int HALF = PSUM_WIDTH / 2;

    logic [PSUM_WIDTH-1:0] full_prod;
    logic [HALF-1:0]       hi_prod;
    logic [HALF-1:0]       lo_prod;

    assign full_prod = PSUM_WIDTH'(a) * PSUM_WIDTH'(b);
    assign hi_prod   = HALF'(a[7:4]) * HALF'(b);
    assign lo_prod   = HALF'(a[3:0]) * HALF'(b);

    // Each lane is laid out exactly on its accumulator half.
    assign prod = mode ? {hi_prod, lo_prod} : full_prod;

endmodule

// File: rtl/psum_lane_acc.sv
// One lane of the partial-sum accumulator.
//
// Two of these are chained: the lower lane's carry_out feeds the upper
// lane's carry_in when a single full-width add is wanted.
//
// Build option: MAC_SEQ_SAT_EN adds a 'clamp' input that forces the lane to
// all-ones instead of taking the wrapped sum. Without it, the lane wraps.
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   clr         load zero (start of a new job), has priority over en
//   en          accumulate addend + carry_in this cycle
//   addend      value to add
//   carry_in    carry from the lane below (0 when lanes are independent)
//   clamp       (MAC_SEQ_SAT_EN only) saturate to all-ones instead
//   carry_out   carry out of this lane's add, combinational
//   acc         registered lane value
module psum_lane_acc #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] addend,
    input  logic         carry_in,
`ifdef MAC_SEQ_SAT_EN
    input  logic         clamp,
`endif
    output logic         carry_out,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W:0]   sum;

    // One extra bit captures the carry for chaining and saturation.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, addend} + {{W{1'b0}}, carry_in};
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
`ifdef MAC_SEQ_SAT_EN
            acc_d = clamp ? {W{1'b1}} : sum[W-1:0];
`else
            acc_d = sum[W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign carry_out = sum[W];
    assign acc       = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job-level sequencer for the dual-mode 8b / 2x4b multiplier.
//
// Accepts a job (mode, length), streams that many operand pairs through one
// multiplier, accumulates the products and hands back one partial sum.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   cfg_valid/cfg_ready      job request handshake (ready only in IDLE)
//   cfg_mode, cfg_len        job mode (0: 8x8, 1: two 4x8 lanes) and beat count
//   op_valid/op_ready        operand beat handshake (ready only in RUN)
//   op_a, op_b               unsigned operands
//   psum_valid/psum_ready    result handshake (valid only in OUT)
//   psum                     accumulated result, straight from the accumulator
//   busy                     sequencer is not idle
//
// Build option: MAC_SEQ_SAT_EN makes every accumulation saturate (full width
// in mode 0, per lane in mode 1) instead of wrapping.
module mac_seq_ctrl
    import diff_demo_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_mode,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [7:0]            op_a,
    input  logic [7:0]            op_b,
    output logic                  psum_valid,
    input  logic                  psum_ready,
    output logic [PSUM_WIDTH-1:0] psum,
    output logic                  busy
);

    localparam int LANE_W = PSUM_WIDTH / 2;

    mac_seq_state_e   state_q, state_d;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;

    logic                  acc_clr;
    logic [PSUM_WIDTH-1:0] prod;
    logic [LANE_W-1:0]     acc_lo;
    logic [LANE_W-1:0]     acc_hi;
    logic                  carry_lo;
    logic                  chain_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MS_IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    // Stage 1 valid is a one-cycle pulse per accepted beat; the accumulator
    // adds on the edge after the beat lands, which is why DRAIN exists.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        count_d    = count_q;
        s1_valid_d = 1'b0;
        a_d        = a_q;
        b_d        = b_q;
        acc_clr    = 1'b0;
        cfg_ready  = 1'b0;
        op_ready   = 1'b0;
        psum_valid = 1'b0;

        case (state_q)
            MS_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    mode_d  = cfg_mode;
                    len_d   = cfg_len;
                    count_d = '0;
                    acc_clr = 1'b1;
                    state_d = (cfg_len == '0) ? MS_OUT : MS_RUN;
                end
            end
            MS_RUN: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    s1_valid_d = 1'b1;
                    count_d    = count_q + LEN_W'(1);
                    if (count_q == len_q - LEN_W'(1)) begin
                        state_d = MS_DRAIN;
                    end
                end
            end
            MS_DRAIN: begin
                state_d = MS_OUT;
            end
            MS_OUT: begin
                psum_valid = 1'b1;
                if (psum_ready) begin
                    state_d = MS_IDLE;
                end
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    dual_mode_mult u_mult (
        .mode (mode_q),
        .a    (a_q),
        .b    (b_q),
        .prod (prod)
    );

    // Mode 0 lets the lower lane's carry ripple into the upper lane so the
    // pair acts as one full-width adder; mode 1 cuts the chain.
    assign chain_in = ~mode_q & carry_lo;

`ifdef MAC_SEQ_SAT_EN
    logic carry_hi;
    logic clamp_lo;

    // A full-width overflow shows up as the upper lane's carry, so in mode 0
    // both halves clamp together on it.
    assign clamp_lo = mode_q ? carry_lo : carry_hi;

    psum_lane_acc #(.W(LANE_W)) u_lane_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr),
        .en        (s1_valid_q),
        .addend    (prod[LANE_W-1:0]),
        .carry_in  (1'b0),
        .clamp     (clamp_lo),
        .carry_out (carry_lo),
        .acc       (acc_lo)
    );

    psum_lane_acc #(.W(LANE_W)) u_lane_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr),
        .en        (s1_valid_q),
        .addend    (prod[PSUM_WIDTH-1:LANE_W]),
        .carry_in  (chain_in),
        .clamp     (carry_hi),
        .carry_out (carry_hi),
        .acc       (acc_hi)
    );
`else
    logic unused_carry_hi;

    psum_lane_acc #(.W(LANE_W)) u_lane_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr),
        .en        (s1_valid_q),
        .addend    (prod[LANE_W-1:0]),
        .carry_in  (1'b0),
        .carry_out (carry_lo),
        .acc       (acc_lo)
    );

    psum_lane_acc #(.W(LANE_W)) u_lane_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr),
        .en        (s1_valid_q),
        .addend    (prod[PSUM_WIDTH-1:LANE_W]),
        .carry_in  (chain_in),
        .carry_out (unused_carry_hi),
        .acc       (acc_hi)
    );
`endif

    assign psum = {acc_hi, acc_lo};
    assign busy = (state_q != MS_IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: a table of directed jobs, an abort by
// reset mid-job, then randomized jobs checked against a sum-of-products model.
module tb_mac_seq_ctrl;
    import diff_demo_pkg::*;

    localparam int LEN_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  cfg_mode;
    logic [LEN_W-1:0]      cfg_len;
    logic                  op_valid;
    logic                  op_ready;
    logic [7:0]            op_a;
    logic [7:0]            op_b;
    logic                  psum_valid;
    logic                  psum_ready;
    logic [PSUM_WIDTH-1:0] psum;
    logic                  busy;

    int nVectors     = 0;
    int nMiscompares = 0;

    logic [7:0] beatA [256];
    logic [7:0] beatB [256];

    typedef struct {
        logic        mode;
        int          len;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [23:0] expPsum;
        int          hold;
        bit          gaps;
    } vec_t;

    vec_t vecs [9];

    mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_len    (cfg_len),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum       (psum),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Result of a job over beatA/beatB[0..len-1], straight from the arithmetic
    // rules: plain integer sums, reduced at the end.
    function automatic logic [23:0] refPsum(input logic mode, input int len);
        longint full = 0;
        longint hi   = 0;
        longint lo   = 0;
        for (int i = 0; i < len; i++) begin
            full += longint'(beatA[i]) * longint'(beatB[i]);
            hi   += longint'(beatA[i] >> 4) * longint'(beatB[i]);
            lo   += longint'(beatA[i] & 8'h0F) * longint'(beatB[i]);
        end
`ifdef MAC_SEQ_SAT_EN
        if (full > 64'hFF_FFFF) full = 64'hFF_FFFF;
        if (hi > 4095) hi = 4095;
        if (lo > 4095) lo = 4095;
`else
        full = full % (64'd1 << 24);
        hi   = hi % 4096;
        lo   = lo % 4096;
`endif
        return mode ? {hi[11:0], lo[11:0]} : full[23:0];
    endfunction

    // Runs one complete job starting from IDLE, with beats from beatA/beatB.
    task automatic applyStimulus(input logic mode, input int len, input bit gaps,
                                 input int hold, input logic [23:0] expected,
                                 input string name);
        int i;
        int cycles;
        logic [23:0] held;
        bit stableOk;

        @(negedge clk);
        checkOutput({name, ".cfgReadyIdle"}, cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_len   = LEN_W'(len);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_mode  = ~mode;

        if (len == 0) begin
            checkOutput({name, ".opReadyLen0"}, op_ready, 0);
            checkOutput({name, ".validLen0"}, psum_valid, 1);
        end else begin
            checkOutput({name, ".busyRun"}, busy, 1);
            i = 0;
            cycles = 0;
            while (i < len && cycles < 4 * len + 50) begin
                // Stray job requests while running must be ignored.
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_len   = LEN_W'($urandom);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    op_valid = 1'b0;
                    op_a     = 8'($urandom);
                end else begin
                    op_valid = 1'b1;
                    op_a     = beatA[i];
                    op_b     = beatB[i];
                    if (op_ready) i++;
                end
                cycles++;
                @(negedge clk);
            end
            cfg_valid = 1'b0;
            if (i < len) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL %s.beatTimeout: got %0d beats, want %0d", name, i, len);
            end
            // Garbage beat during DRAIN must not be taken.
            op_valid = 1'b1;
            op_a     = 8'($urandom);
            op_b     = 8'($urandom);
            checkOutput({name, ".validDrain"}, psum_valid, 0);
            checkOutput({name, ".opReadyDrain"}, op_ready, 0);
            @(negedge clk);
            checkOutput({name, ".validLatency"}, psum_valid, 1);
        end

        checkOutput({name, ".psum"}, psum, expected);
        held     = psum;
        stableOk = 1'b1;
        for (int k = 0; k < hold; k++) begin
            psum_ready = 1'b0;
            cfg_valid  = 1'b1;
            cfg_len    = LEN_W'($urandom);
            op_valid   = 1'b1;
            op_a       = 8'($urandom);
            op_b       = 8'($urandom);
            @(negedge clk);
            if (psum_valid !== 1'b1 || psum !== held || cfg_ready !== 1'b0 ||
                op_ready !== 1'b0) stableOk = 1'b0;
        end
        checkOutput({name, ".holdStable"}, stableOk, 1);
        checkOutput({name, ".psumHeld"}, psum, expected);

        cfg_valid  = 1'b0;
        op_valid   = 1'b0;
        psum_ready = 1'b1;
        @(negedge clk);
        psum_ready = 1'b0;
        checkOutput({name, ".validAfter"}, psum_valid, 0);
        checkOutput({name, ".cfgReadyAfter"}, cfg_ready, 1);
        checkOutput({name, ".busyAfter"}, busy, 0);
    endtask

    initial begin
        #200000;
        nMiscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        logic [23:0] exp3;
        logic [23:0] exp8;
        logic        rmode;
        int          rlen;

`ifdef MAC_SEQ_SAT_EN
        exp3 = 24'hFFFFFF;
        exp8 = 24'hFFFFFF;
`else
        exp3 = 24'hDE2DE2;
        exp8 = 24'h20F20F;
`endif
        vecs[0] = '{1'b0,   3, 8'd255,  8'd255, 24'h02FA03, 1, 1'b0};
        vecs[1] = '{1'b1,   2, 8'h31,   8'd200, 24'h4B0190, 1, 1'b0};
        vecs[2] = '{1'b1,   2, 8'hFF,   8'hFF,  exp3,       1, 1'b0};
        vecs[3] = '{1'b0,   2, 8'd10,   8'd20,  24'h000190, 5, 1'b0};
        vecs[4] = '{1'b0,   0, 8'd0,    8'd0,   24'h000000, 2, 1'b0};
        vecs[5] = '{1'b0,   1, 8'd2,    8'd3,   24'h000006, 1, 1'b0};
        vecs[6] = '{1'b1,   1, 8'h12,   8'd10,  24'h00A014, 2, 1'b1};
        vecs[7] = '{1'b0, 255, 8'd255,  8'd255, 24'hFD02FF, 1, 1'b1};
        vecs[8] = '{1'b1, 255, 8'd255,  8'd255, exp8,       3, 1'b0};

        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_mode   = 1'b0;
        cfg_len    = '0;
        op_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        psum_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset.cfgReady", cfg_ready, 1);
        checkOutput("reset.opReady", op_ready, 0);
        checkOutput("reset.psumValid", psum_valid, 0);
        checkOutput("reset.psum", psum, 0);
        checkOutput("reset.busy", busy, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            for (int j = 0; j < 256; j++) begin
                beatA[j] = vecs[v].a;
                beatB[j] = vecs[v].b;
            end
            applyStimulus(vecs[v].mode, vecs[v].len, vecs[v].gaps, vecs[v].hold,
                          vecs[v].expPsum, $sformatf("vec%0d", v));
        end

        // Abort a job by reset after two of four beats.
        beatA[0] = 8'd200;
        beatB[0] = 8'd100;
        beatA[1] = 8'd17;
        beatB[1] = 8'd250;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_mode  = 1'b0;
        cfg_len   = LEN_W'(4);
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("abort.opReady%0d", j), op_ready, 1);
            op_valid = 1'b1;
            op_a     = beatA[j];
            op_b     = beatB[j];
            @(negedge clk);
        end
        op_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("abort.cfgReady", cfg_ready, 1);
        checkOutput("abort.opReady", op_ready, 0);
        checkOutput("abort.psumValid", psum_valid, 0);
        checkOutput("abort.psum", psum, 0);
        checkOutput("abort.busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beatA[0] = 8'd2;
        beatB[0] = 8'd3;
        applyStimulus(1'b0, 1, 1'b0, 1, 24'd6, "postAbort");

        // Randomized jobs against the reference model.
        for (int r = 0; r < 25; r++) begin
            rmode = 1'($urandom_range(0, 1));
            rlen  = (r % 8 == 7) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 12));
            for (int j = 0; j < 256; j++) begin
                beatA[j] = 8'($urandom);
                beatB[j] = 8'($urandom);
            end
            applyStimulus(rmode, rlen, 1'b1, int'($urandom_range(1, 4)),
                          refPsum(rmode, rlen), $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
